// File: rtl/sig_mem_arbiter_pkg.sv
// Shared signal-RAM constants and types for the trace writers and the display controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sig_mem_arbiter_pkg;

    localparam int ADDR_W   = 12;
    localparam int PTR_W    = 10;
    localparam int DATA_W   = 32;
    localparam int SAMPLE_W = 12;

    localparam logic [ADDR_W-1:0] ECG_BASE_DEF = 12'h801;
    localparam logic [ADDR_W-1:0] EMG_BASE_DEF = 12'h581;
    localparam int                DEPTH_DEF    = 640;

    // Which sample writer won the most recent completed write.
    typedef enum logic {
        GNT_ECG = 1'b0,
        GNT_EMG = 1'b1
    } grant_t;

    // One RAM access as presented on the memory port.
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              we;
        logic [DATA_W-1:0] wdata;
    } mem_req_t;

    // Zero-extend a sample into a RAM word.
    function automatic logic [DATA_W-1:0] sample_word(input logic [SAMPLE_W-1:0] s);
        return {{(DATA_W-SAMPLE_W){1'b0}}, s};
    endfunction

endpackage

// File: rtl/sig_ring_ptr.sv
// Trace ring write pointer with wrap at DEPTH-1, plus a head latched on frame_end.
// Latency: pointer and head update on the clock edge after adv / frame_end.
// Backpressure: none; advances only when the parent reports a completed write.
module sig_ring_ptr
    import sig_mem_arbiter_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             adv,
    input  logic             frame_end,
    output logic [PTR_W-1:0] wptr,
    output logic [PTR_W-1:0] head
);

    localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);
    localparam logic [PTR_W-1:0] ONE  = PTR_W'(1);

    logic [PTR_W-1:0] wptr_nxt;

    // Next pointer value, including any write completing this cycle.
    always_comb begin
        wptr_nxt = wptr;
        if (adv) begin
            wptr_nxt = (wptr == LAST) ? '0 : wptr + ONE;
        end
    end

    // Pointer follows writes; head snapshots the post-increment pointer at frame end.
    always_ff @(posedge clock) begin
        if (!reset) begin
            wptr <= '0;
            head <= '0;
        end else begin
            wptr <= wptr_nxt;
            if (frame_end) begin
                head <= wptr_nxt;
            end
        end
    end

endmodule

// File: rtl/sig_mem_arbiter.sv
// Single-port signal-RAM arbiter: display reads win, ECG/EMG sample writes share round-robin.
// Latency: writes land in the grant cycle; vga_valid follows a read request by one cycle.
// Backpressure: writers see ready=0 while the display reads or the other trace holds the turn.
module sig_mem_arbiter
    import sig_mem_arbiter_pkg::*;
#(
    parameter logic [ADDR_W-1:0] ECG_BASE = ECG_BASE_DEF,
    parameter logic [ADDR_W-1:0] EMG_BASE = EMG_BASE_DEF,
    parameter int                DEPTH    = DEPTH_DEF
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                vga_req,
    input  logic [ADDR_W-1:0]   vga_addr,
    output logic                vga_valid,
    output logic [DATA_W-1:0]   vga_data,
    input  logic                ecg_valid,
    input  logic [SAMPLE_W-1:0] ecg_data,
    output logic                ecg_ready,
    input  logic                emg_valid,
    input  logic [SAMPLE_W-1:0] emg_data,
    output logic                emg_ready,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic                mem_we,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata,
    input  logic                frame_end,
    output logic [PTR_W-1:0]    ecg_head,
    output logic [PTR_W-1:0]    emg_head
);

    grant_t           last_gnt;
    logic             ecg_gnt;
    logic             emg_gnt;
    logic [PTR_W-1:0] ecg_wptr;
    logic [PTR_W-1:0] emg_wptr;
    mem_req_t         req;

    // Write grant: display has the port first; on a tie the trace not served last wins.
    // Reset gates the grants so no write can slip through in a reset cycle.
    always_comb begin
        ecg_gnt = 1'b0;
        emg_gnt = 1'b0;
        if (reset && !vga_req) begin
            if (ecg_valid && (!emg_valid || last_gnt == GNT_EMG)) begin
                ecg_gnt = 1'b1;
            end else if (emg_valid) begin
                emg_gnt = 1'b1;
            end
        end
    end

    assign ecg_ready = ecg_gnt;
    assign emg_ready = emg_gnt;

    // RAM port mux: read address for display, ring slot for the granted trace, else parked at 0.
    always_comb begin
        req = '0;
        if (vga_req) begin
            req.addr = vga_addr;
        end else if (ecg_gnt) begin
            req.addr  = ECG_BASE + {{(ADDR_W-PTR_W){1'b0}}, ecg_wptr};
            req.we    = 1'b1;
            req.wdata = sample_word(ecg_data);
        end else if (emg_gnt) begin
            req.addr  = EMG_BASE + {{(ADDR_W-PTR_W){1'b0}}, emg_wptr};
            req.we    = 1'b1;
            req.wdata = sample_word(emg_data);
        end
    end

    assign mem_addr  = req.addr;
    assign mem_we    = req.we;
    assign mem_wdata = req.wdata;

    // Round-robin state: moves only on a completed write, display cycles leave it alone.
    always_ff @(posedge clock) begin
        if (!reset) begin
            last_gnt <= GNT_EMG;
        end else if (ecg_gnt) begin
            last_gnt <= GNT_ECG;
        end else if (emg_gnt) begin
            last_gnt <= GNT_EMG;
        end
    end

    // Read data returns one cycle after the request, straight from the RAM.
    always_ff @(posedge clock) begin
        if (!reset) begin
            vga_valid <= 1'b0;
        end else begin
            vga_valid <= vga_req;
        end
    end

    assign vga_data = mem_rdata;

    sig_ring_ptr #(.DEPTH(DEPTH)) u_ecg_ptr (
        .clock     (clock),
        .reset     (reset),
        .adv       (ecg_gnt),
        .frame_end (frame_end),
        .wptr      (ecg_wptr),
        .head      (ecg_head)
    );

    sig_ring_ptr #(.DEPTH(DEPTH)) u_emg_ptr (
        .clock     (clock),
        .reset     (reset),
        .adv       (emg_gnt),
        .frame_end (frame_end),
        .wptr      (emg_wptr),
        .head      (emg_head)
    );

endmodule

// File: tb/tb_sig_mem_arbiter.sv
// Bench for sig_mem_arbiter: directed scenarios then random traffic against a reference model.
// Latency: n/a.
// Backpressure: writers hold valid/data until accepted.
module tb_sig_mem_arbiter;

    logic        clock;
    logic        reset;
    logic        vga_req;
    logic [11:0] vga_addr;
    logic        vga_valid;
    logic [31:0] vga_data;
    logic        ecg_valid;
    logic [11:0] ecg_data;
    logic        ecg_ready;
    logic        emg_valid;
    logic [11:0] emg_data;
    logic        emg_ready;
    logic [11:0] mem_addr;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        frame_end;
    logic [9:0]  ecg_head;
    logic [9:0]  emg_head;

    int checks = 0;
    int errors = 0;

    sig_mem_arbiter dut (
        .clock     (clock),
        .reset     (reset),
        .vga_req   (vga_req),
        .vga_addr  (vga_addr),
        .vga_valid (vga_valid),
        .vga_data  (vga_data),
        .ecg_valid (ecg_valid),
        .ecg_data  (ecg_data),
        .ecg_ready (ecg_ready),
        .emg_valid (emg_valid),
        .emg_data  (emg_data),
        .emg_ready (emg_ready),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .frame_end (frame_end),
        .ecg_head  (ecg_head),
        .emg_head  (emg_head)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Single-port synchronous RAM, 1-cycle read latency.
    logic [31:0] ram [4096];
    always @(posedge clock) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    function automatic logic [31:0] pat(input int i);
        return 32'hA500_0000 ^ (i * 32'h0001_0001);
    endfunction

    // Reference model state: what the RAM should hold and where each trace stands.
    logic [31:0] exp_mem [4096];
    int          m_ecg_ptr, m_emg_ptr, m_ecg_head, m_emg_head;
    bit          m_last_emg;
    bit          m_vvalid;
    int          m_vaddr;

    // Observations from the latest cycle, for directed checks.
    logic [11:0] obs_addr;
    logic        obs_we, obs_ecg_rdy, obs_emg_rdy;
    bit          xfer_ecg, xfer_emg;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic model_reset();
        m_ecg_ptr = 0; m_emg_ptr = 0; m_ecg_head = 0; m_emg_head = 0;
        m_last_emg = 1'b1; m_vvalid = 1'b0; m_vaddr = 0;
    endtask

    // One clock: inputs already driven; check outputs, clock, advance the model.
    task automatic cycle();
        int          pick;
        logic [11:0] e_addr;
        logic [31:0] e_wd;
        bit          r_n, vr, fe;
        int          va;
        #1;
        pick = 0;
        if (reset && !vga_req) begin
            if (ecg_valid && emg_valid) pick = m_last_emg ? 1 : 2;
            else if (ecg_valid)         pick = 1;
            else if (emg_valid)         pick = 2;
        end
        e_addr = vga_req ? vga_addr :
                 (pick == 1) ? 12'(32'h801 + m_ecg_ptr) :
                 (pick == 2) ? 12'(32'h581 + m_emg_ptr) : 12'h000;
        e_wd   = (pick == 1) ? {20'b0, ecg_data} : (pick == 2) ? {20'b0, emg_data} : 32'h0;
        chk("ecg_ready", ecg_ready, (pick == 1));
        chk("emg_ready", emg_ready, (pick == 2));
        chk("mem_we", mem_we, (pick != 0));
        if (reset) chk("mem_addr", mem_addr, e_addr);
        if (pick != 0) chk("mem_wdata", mem_wdata, e_wd);
        chk("vga_valid", vga_valid, m_vvalid);
        if (m_vvalid) chk("vga_data", vga_data, exp_mem[m_vaddr]);
        chk("ecg_head", ecg_head, m_ecg_head);
        chk("emg_head", emg_head, m_emg_head);
        obs_addr = mem_addr; obs_we = mem_we;
        obs_ecg_rdy = ecg_ready; obs_emg_rdy = emg_ready;
        xfer_ecg = (pick == 1); xfer_emg = (pick == 2);
        r_n = reset; vr = vga_req; va = vga_addr; fe = frame_end;
        @(posedge clock);
        if (!r_n) begin
            model_reset();
        end else begin
            m_vvalid = vr; m_vaddr = va;
            if (pick == 1) begin
                exp_mem[e_addr] = e_wd; m_ecg_ptr = (m_ecg_ptr + 1) % 640; m_last_emg = 1'b0;
            end else if (pick == 2) begin
                exp_mem[e_addr] = e_wd; m_emg_ptr = (m_emg_ptr + 1) % 640; m_last_emg = 1'b1;
            end
            if (fe) begin
                m_ecg_head = m_ecg_ptr; m_emg_head = m_emg_ptr;
            end
        end
        @(negedge clock);
    endtask

    task automatic idle_inputs();
        vga_req = 0; vga_addr = 12'h000; ecg_valid = 0; emg_valid = 0; frame_end = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 0;
        cycle();
        reset = 1;
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) begin
            ram[i] = pat(i);
            exp_mem[i] = pat(i);
        end
        model_reset();
        reset = 0; vga_req = 1; vga_addr = 12'h123;
        ecg_valid = 1; emg_valid = 1; ecg_data = 12'h111; emg_data = 12'h222; frame_end = 0;
        @(negedge clock);

        // Reset state with traffic pending.
        cycle();
        chk("rst_we", obs_we, 1'b0);
        chk("rst_ecg_rdy", obs_ecg_rdy, 1'b0);
        chk("rst_vga_valid", vga_valid, 1'b0);
        chk("rst_ecg_head", ecg_head, 10'd0);

        // Release with both writers valid: ECG first, then alternating.
        reset = 1; vga_req = 0;
        cycle(); chk("rr_first_ecg", obs_addr, 12'h801);
        emg_data = 12'h333;
        cycle(); chk("rr_then_emg", obs_addr, 12'h581);
        ecg_data = 12'h444;
        cycle(); chk("rr_ecg2", obs_addr, 12'h802);
        cycle(); chk("rr_emg2", obs_addr, 12'h582);

        // Display read held 3 cycles stalls the ECG writer.
        emg_valid = 0; ecg_valid = 1; ecg_data = 12'h5A5;
        vga_req = 1; vga_addr = 12'h900;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("vga_stall_rdy", obs_ecg_rdy, 1'b0);
            chk("vga_valid_hi", vga_valid, 1'b1);
            chk("vga_data_900", vga_data, pat(12'h900));
        end
        vga_req = 0;
        cycle();
        chk("post_vga_we", obs_we, 1'b1);
        chk("post_vga_addr", obs_addr, 12'h803);
        chk("post_vga_vld_lo", vga_valid, 1'b0);

        // 641 ECG writes: wrap from slot 639 back to slot 0.
        do_reset();
        ecg_valid = 1;
        for (int i = 1; i <= 641; i++) begin
            ecg_data = 12'(i);
            cycle();
            if (i == 640) chk("wrap_640th", obs_addr, 12'hA80);
            if (i == 641) chk("wrap_641st", obs_addr, 12'h801);
        end
        ecg_valid = 0; frame_end = 1;
        cycle();
        frame_end = 0;
        chk("wrap_wptr_1", ecg_head, 10'd1);

        // frame_end together with the write at wptr=5 latches 6.
        do_reset();
        ecg_valid = 1;
        repeat (5) cycle();
        frame_end = 1;
        cycle();
        frame_end = 0;
        chk("fe_head_6", ecg_head, 10'd6);
        repeat (3) cycle();
        chk("fe_head_stable", ecg_head, 10'd6);
        ecg_valid = 0;

        // Random traffic; writers hold valid/data until accepted.
        for (int n = 0; n < 400; n++) begin
            reset     = ($urandom_range(63) != 0);
            vga_req   = ($urandom_range(2) == 0);
            vga_addr  = 12'($urandom);
            frame_end = ($urandom_range(15) == 0);
            if (!ecg_valid) begin ecg_valid = $urandom_range(1) == 1; ecg_data = 12'($urandom); end
            if (!emg_valid) begin emg_valid = $urandom_range(1) == 1; emg_data = 12'($urandom); end
            cycle();
            if (xfer_ecg) ecg_valid = 0;
            if (xfer_emg) emg_valid = 0;
        end

        // Reset landing on an EMG grant suppresses the write and clears EMG state.
        do_reset();
        emg_valid = 1; emg_data = 12'h0AB;
        cycle();
        frame_end = 1;
        cycle();
        frame_end = 0;
        chk("emg_head_pre", emg_head, 10'd2);
        reset = 0;
        cycle();
        chk("rst_mid_we", obs_we, 1'b0);
        reset = 1; emg_valid = 0; frame_end = 1;
        cycle();
        frame_end = 0;
        chk("rst_mid_head", emg_head, 10'd0);
        emg_valid = 1;
        cycle();
        chk("rst_mid_ptr", obs_addr, 12'h581);
        idle_inputs();
        cycle();
        chk("idle_addr", obs_addr, 12'h000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
